// File: rtl/cdb_arbiter_if.sv
// Common data bus request/broadcast bundle.
// The master side is the requester pool and the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32
);
    // A transfer happens in any cycle where req_valid[i] & req_ready[i].
    // The requester holds valid, label and value stable until it is granted.
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*LABEL_W-1:0] req_label;
    logic [N_REQ*DATA_W-1:0]  req_value;
    logic [N_REQ-1:0]         req_ready;
    logic                     hold;
    logic                     cdb_valid;
    logic [LABEL_W-1:0]       cdb_label;
    logic [DATA_W-1:0]        cdb_value;

    modport master (
        output req_valid, req_label, req_value, hold,
        input  req_ready, cdb_valid, cdb_label, cdb_value
    );

    modport slave (
        input  req_valid, req_label, req_value, hold,
        output req_ready, cdb_valid, cdb_label, cdb_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one registered broadcast per cycle.
// Define CDB_STALL_CNT_EN to build the saturating contention counter.
module cdb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    cdb_arbiter_if.slave bus,
    output logic         err_label0,
    output logic [15:0]  stall_cnt
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic               found_hi;
    logic               found_lo;
    logic [PTR_W-1:0]   hi_idx;
    logic [PTR_W-1:0]   lo_idx;
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]   gnt_oh;
    logic [LABEL_W-1:0] win_label;
    logic [DATA_W-1:0]  win_value;

    // Search at or above ptr first; otherwise wrap to the lowest valid index.
    always_comb begin
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_hi && bus.req_valid[i] && (PTR_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                hi_idx   = PTR_W'(i);
            end
            if (!found_lo && bus.req_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = PTR_W'(i);
            end
        end
        gnt_any = (found_hi || found_lo) && !bus.hold && rst_n;
        gnt_idx = found_hi ? hi_idx : lo_idx;

        gnt_oh    = '0;
        win_label = '0;
        win_value = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                gnt_oh[i] = gnt_any;
                win_label = bus.req_label[i*LABEL_W +: LABEL_W];
                win_value = bus.req_value[i*DATA_W +: DATA_W];
            end
        end

        ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign bus.req_ready = gnt_oh;

    // Label 0 means "no producer": consume the request but never broadcast it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_label <= '0;
            bus.cdb_value <= '0;
            err_label0    <= 1'b0;
        end else begin
            bus.cdb_valid <= gnt_any && (win_label != '0);
            err_label0    <= gnt_any && (win_label == '0);
            if (gnt_any) begin
                ptr <= ptr_next;
                if (win_label != '0) begin
                    bus.cdb_label <= win_label;
                    bus.cdb_value <= win_value;
                end
            end
        end
    end

`ifdef CDB_STALL_CNT_EN
    logic stall_evt;

    // Any pending request left waiting this cycle, through lost contention or hold.
    assign stall_evt = |(bus.req_valid & ~gnt_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run,
// with a due-cycle tagged scoreboard for CDB broadcasts and label-0 errors.
module tb_cdb_arbiter;
    localparam int N_REQ   = 4;
    localparam int LABEL_W = 4;
    localparam int DATA_W  = 32;
    localparam int EW      = 16 + LABEL_W + DATA_W;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_label0;
    logic [15:0] stall_cnt;

    cdb_arbiter_if #(.N_REQ(N_REQ), .LABEL_W(LABEL_W), .DATA_W(DATA_W)) bus();

    cdb_arbiter #(.N_REQ(N_REQ), .LABEL_W(LABEL_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_label0 (err_label0),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [15:0]        cyc_n    = 16'd0;
    bit                 mon_en   = 1'b0;
    logic [EW-1:0]      exp_q[$];
    logic [15:0]        err_q[$];
    logic [LABEL_W-1:0] lab[N_REQ];
    logic [DATA_W-1:0]  val[N_REQ];

    always @(posedge clk) cyc_n <= cyc_n + 16'd1;

    // Scoreboard: each entry carries the cycle in which it must appear on the CDB.
    always @(negedge clk) begin : monitor
        logic          exp_v;
        logic          exp_e;
        logic [EW-1:0] e;
        if (mon_en && rst_n) begin
            while (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] < cyc_n) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_bcast: label %0d value %h never seen (due cycle %0d)",
                         e[DATA_W +: LABEL_W], e[DATA_W-1:0], e[EW-1 -: 16]);
            end
            while (err_q.size() > 0 && err_q[0] < cyc_n) begin
                void'(err_q.pop_front());
                n_checks++;
                n_fail++;
                $display("FAIL missing_err_label0: pulse not seen");
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0][EW-1 -: 16] == cyc_n);
            exp_e = (err_q.size() > 0) && (err_q[0] == cyc_n);
            n_checks++;
            if (bus.cdb_valid !== exp_v) begin
                n_fail++;
                $display("FAIL cdb_valid: cycle %0d got %b expected %b", cyc_n, bus.cdb_valid, exp_v);
            end
            if (exp_v) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.cdb_label, bus.cdb_value} !== e[LABEL_W+DATA_W-1:0]) begin
                    n_fail++;
                    $display("FAIL cdb_data: cycle %0d got label %0d value %h expected label %0d value %h",
                             cyc_n, bus.cdb_label, bus.cdb_value, e[DATA_W +: LABEL_W], e[DATA_W-1:0]);
                end
            end
            if (exp_e) void'(err_q.pop_front());
            n_checks++;
            if (err_label0 !== exp_e) begin
                n_fail++;
                $display("FAIL err_label0: cycle %0d got %b expected %b", cyc_n, err_label0, exp_e);
            end
        end
    end

    task automatic apply_bus();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_label[i*LABEL_W +: LABEL_W] = lab[i];
            bus.req_value[i*DATA_W +: DATA_W]   = val[i];
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic h);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.hold      = h;
        apply_bus();
        @(negedge clk);
    endtask

    task automatic push_bcast(input int g);
        exp_q.push_back({cyc_n + 16'd1, lab[g], val[g]});
    endtask

    task automatic push_err();
        err_q.push_back(cyc_n + 16'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.hold      = 1'b0;
        exp_q.delete();
        err_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N_REQ; i++) begin
            lab[i] = LABEL_W'(i + 1);
            val[i] = $urandom;
        end
        bus.req_valid = 4'b1111;
        bus.hold      = 1'b0;
        apply_bus();
        #12;
        n_checks += 6;
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid: got %b expected 0", bus.cdb_valid); end
        if (bus.cdb_label !== '0) begin n_fail++; $display("FAIL reset_cdb_label: got %0d expected 0", bus.cdb_label); end
        if (bus.cdb_value !== '0) begin n_fail++; $display("FAIL reset_cdb_value: got %h expected 0", bus.cdb_value); end
        if (err_label0 !== 1'b0) begin n_fail++; $display("FAIL reset_err_label0: got %b expected 0", err_label0); end
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", bus.req_ready); end
        push_bcast(0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            lab[i] = LABEL_W'(i + 1);
            val[i] = $urandom;
        end
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b0);
            exp_r = 4'b0001 << (k % 4);
            n_checks++;
            if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, bus.req_ready, exp_r); end
            push_bcast(k % 4);
            val[k % 4] = $urandom;
        end
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_s[3];
        int         gi[3];
        exp_s = '{4'b0001, 4'b0100, 4'b0001};
        gi    = '{0, 2, 0};
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            lab[i] = LABEL_W'(i + 10);
            val[i] = $urandom;
        end
        drive(4'b0100, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b expected 0100", bus.req_ready); end
        push_bcast(2);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0101, 1'b0);
            n_checks++;
            if (bus.req_ready !== exp_s[k]) begin n_fail++; $display("FAIL wrap_grant%0d: got %b expected %b", k, bus.req_ready, exp_s[k]); end
            push_bcast(gi[k]);
            val[gi[k]] = $urandom;
        end
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_hold();
        logic [15:0] exp_st;
        do_reset();
        lab[1] = 4'd5;
        val[1] = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            drive(4'b0010, 1'b1);
            n_checks++;
            if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_nogrant%0d: got %b expected 0000", k, bus.req_ready); end
        end
        drive(4'b0010, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_release: got %b expected 0010", bus.req_ready); end
        push_bcast(1);
        drive(4'b0000, 1'b0);
`ifdef CDB_STALL_CNT_EN
        exp_st = 16'd3;
`else
        exp_st = 16'd0;
`endif
        n_checks++;
        if (stall_cnt !== exp_st) begin n_fail++; $display("FAIL hold_stall_cnt: got %0d expected %0d", stall_cnt, exp_st); end
        lab[1] = 4'd6;
        val[1] = $urandom;
        drive(4'b0010, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_mid_grant: got %b expected 0010", bus.req_ready); end
        push_bcast(1);
        val[1] = $urandom;
        drive(4'b0010, 1'b1);
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_mid_stall: got %b expected 0000", bus.req_ready); end
        drive(4'b0010, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_mid_resume: got %b expected 0010", bus.req_ready); end
        push_bcast(1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_label0();
        do_reset();
        lab[0] = 4'd0;
        val[0] = $urandom;
        lab[1] = 4'd7;
        val[1] = $urandom;
        drive(4'b0001, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL label0_grant: got %b expected 0001", bus.req_ready); end
        push_err();
        drive(4'b0011, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL label0_ptr_adv: got %b expected 0010", bus.req_ready); end
        push_bcast(1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        lab[3] = 4'd9;
        for (int k = 0; k < 6; k++) begin
            val[3] = $urandom;
            drive(4'b1000, 1'b0);
            n_checks++;
            if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL b2b_grant%0d: got %b expected 1000", k, bus.req_ready); end
            push_bcast(3);
        end
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        lab[0] = 4'd3;
        val[0] = $urandom;
        lab[1] = 4'd4;
        val[1] = $urandom;
        drive(4'b0011, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_grant: got %b expected 0001", bus.req_ready); end
        @(posedge clk);
        #2;
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_label !== 4'd3) begin
            n_fail++;
            $display("FAIL arst_pre_bcast: got valid %b label %0d expected valid 1 label 3", bus.cdb_valid, bus.cdb_label);
        end
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_cdb_valid: got %b expected 0", bus.cdb_valid); end
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL arst_ready: got %b expected 0000", bus.req_ready); end
        bus.req_valid = '0;
        exp_q.delete();
        err_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 1'b0);
        drive(4'b1111, 1'b0);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_ptr_zero: got %b expected 0001", bus.req_ready); end
        push_bcast(0);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
    endtask

    function automatic int model_grant(input logic [3:0] v, input int p, input logic h);
        int idx;
        if (h) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (p + k) % N_REQ;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] exp_r;
        logic       h;
        int         mptr;
        int         g;
        do_reset();
        mptr = 0;
        pend = '0;
        for (int i = 0; i < N_REQ; i++) begin
            lab[i] = LABEL_W'($urandom_range(0, 15));
            val[i] = $urandom;
        end
        for (int k = 0; k < 40; k++) begin
            pend = pend | 4'($urandom_range(0, 15));
            h    = ($urandom_range(0, 5) == 0);
            drive(pend, h);
            g     = model_grant(pend, mptr, h);
            exp_r = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_checks++;
            if (bus.req_ready !== exp_r) begin n_fail++; $display("FAIL rand_grant%0d: got %b expected %b", k, bus.req_ready, exp_r); end
            if (g >= 0) begin
                if (lab[g] != '0) push_bcast(g);
                else push_err();
                mptr        = (g + 1) % N_REQ;
                lab[g]      = LABEL_W'($urandom_range(0, 15));
                val[g]      = $urandom;
                pend[g[1:0]] = 1'($urandom_range(0, 1));
            end
        end
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        n_checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0", exp_q.size(), err_q.size());
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_label = '0;
        bus.req_value = '0;
        bus.hold      = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_hold();
        test_label0();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
